// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - control sequencer for the 16-slice ALU array
// Define ALU_DBL_EN to enable the two-pass 32-bit add (Func E).
module alu_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_func,
  input  logic [3:0] i_sh_amt,
  input  logic       i_nz_chain,
  input  logic       i_cout_msb,
  input  logic       i_a_msb,
  input  logic       i_b_msb,
  input  logic       i_sum_msb,
  input  logic       i_out_msb,
  output logic       o_and,
  output logic       o_or,
  output logic       o_nand,
  output logic       o_nor,
  output logic       o_not,
  output logic       o_xor,
  output logic       o_sub,
  output logic       o_fa_out,
  output logic       o_zero_a,
  output logic       o_sh1,
  output logic       o_sh2,
  output logic       o_sh4,
  output logic       o_sh8,
  output logic       o_shl,
  output logic       o_shr,
  output logic       o_shb,
  output logic       o_sh_out,
  output logic       o_cin_slice0,
  output logic       o_half,
  output logic       o_wr_en,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_z,
  output logic       o_c,
  output logic       o_n,
  output logic       o_v
);

  if (WIDTH < 2) begin : g_width_chk
    $error("alu_ctrl: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EXEC_HI, S_DONE} state_t;

  typedef struct packed {
    logic       f_and;
    logic       f_or;
    logic       f_nand;
    logic       f_nor;
    logic       f_not;
    logic       f_xor;
    logic       sub;
    logic       fa_out;
    logic       zero_a;
    logic [3:0] sh;
    logic       shl;
    logic       shr;
    logic       shb;
    logic       sh_out;
    logic       cin;
    logic       wr_en;
  } sel_t;

  localparam logic [3:0] F_ADD32 = 4'hE;

  function automatic sel_t decode(input logic [3:0] func, input logic [3:0] sh_amt, input logic c);
    sel_t s;
    s = '0;
    s.wr_en = 1'b1;
    case (func)
      4'h0: s.fa_out = 1'b1;
      4'h1: begin s.fa_out = 1'b1; s.cin = c; end
      4'h2: begin s.fa_out = 1'b1; s.sub = 1'b1; s.cin = 1'b1; end
      4'h3: begin s.fa_out = 1'b1; s.sub = 1'b1; s.cin = c; end
      4'h4: s.f_and = 1'b1;
      4'h5: s.f_or = 1'b1;
      4'h6: s.f_xor = 1'b1;
      4'h7: s.f_nand = 1'b1;
      4'h8: s.f_nor = 1'b1;
      4'h9: begin s.f_not = 1'b1; s.zero_a = 1'b1; end
      4'hA: begin s.sh_out = 1'b1; s.shl = 1'b1; s.sh = sh_amt; end
      4'hB: begin s.sh_out = 1'b1; s.shr = 1'b1; s.sh = sh_amt; end
      4'hC: begin s.sh_out = 1'b1; s.shr = 1'b1; s.shb = 1'b1; s.sh = sh_amt; end
      4'hD: begin s.fa_out = 1'b1; s.sub = 1'b1; s.cin = 1'b1; s.wr_en = 1'b0; end
      4'hE: s.fa_out = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  state_t     r_state;
  state_t     w_next;
  sel_t       r_sel;
  sel_t       w_sel;
  logic [3:0] r_func;
  logic       r_err;
  logic       r_z, r_c, r_n, r_v;
  logic       w_legal;
  logic       w_last;
  logic       w_arith;
  logic       w_shift;

`ifdef ALU_DBL_EN
  logic       r_half;
  logic       w_half;
  logic       r_z_lo;
  assign w_legal = (i_func != 4'hF);
`else
  assign w_legal = (i_func != 4'hF) && (i_func != F_ADD32);
`endif

  assign w_arith = (r_func <= 4'h3) || (r_func == 4'hD) || (r_func == F_ADD32);
  assign w_shift = (r_func >= 4'hA) && (r_func <= 4'hC);

  always_comb begin
    w_next = r_state;
    w_sel  = '0;
    w_last = 1'b0;
`ifdef ALU_DBL_EN
    w_half = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_legal) begin
            w_next = S_EXEC;
            w_sel  = decode(i_func, i_sh_amt, r_c);
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_EXEC: begin
`ifdef ALU_DBL_EN
        if (r_func == F_ADD32) begin
          // The CIn register doubles as the low-pass carry latch.
          w_next       = S_EXEC_HI;
          w_sel.fa_out = 1'b1;
          w_sel.cin    = i_cout_msb;
          w_sel.wr_en  = 1'b1;
          w_half       = 1'b1;
        end else begin
          w_next = S_DONE;
          w_last = 1'b1;
        end
`else
        w_next = S_DONE;
        w_last = 1'b1;
`endif
      end
`ifdef ALU_DBL_EN
      S_EXEC_HI: begin
        w_next = S_DONE;
        w_last = 1'b1;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_func  <= 4'h0;
      r_err   <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
`ifdef ALU_DBL_EN
      r_half  <= 1'b0;
      r_z_lo  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel;
      r_err   <= (r_state == S_IDLE) && i_start && !w_legal;
      if (r_state == S_IDLE && i_start) begin
        r_func <= i_func;
      end
`ifdef ALU_DBL_EN
      r_half <= w_half;
      if (r_state == S_EXEC && w_next == S_EXEC_HI) begin
        r_z_lo <= ~i_nz_chain;
      end
`endif
      if (w_last) begin
        r_n <= i_out_msb;
`ifdef ALU_DBL_EN
        r_z <= (r_state == S_EXEC_HI) ? (r_z_lo & ~i_nz_chain) : ~i_nz_chain;
`else
        r_z <= ~i_nz_chain;
`endif
        if (w_arith) begin
          r_c <= i_cout_msb;
          r_v <= (i_a_msb == (i_b_msb ^ r_sel.sub)) && (i_sum_msb != i_a_msb);
        end else if (w_shift) begin
          r_v <= 1'b0;
        end else begin
          r_c <= 1'b0;
          r_v <= 1'b0;
        end
      end
    end
  end

  assign o_and        = r_sel.f_and;
  assign o_or         = r_sel.f_or;
  assign o_nand       = r_sel.f_nand;
  assign o_nor        = r_sel.f_nor;
  assign o_not        = r_sel.f_not;
  assign o_xor        = r_sel.f_xor;
  assign o_sub        = r_sel.sub;
  assign o_fa_out     = r_sel.fa_out;
  assign o_zero_a     = r_sel.zero_a;
  assign o_sh1        = r_sel.sh[0];
  assign o_sh2        = r_sel.sh[1];
  assign o_sh4        = r_sel.sh[2];
  assign o_sh8        = r_sel.sh[3];
  assign o_shl        = r_sel.shl;
  assign o_shr        = r_sel.shr;
  assign o_shb        = r_sel.shb;
  assign o_sh_out     = r_sel.sh_out;
  assign o_cin_slice0 = r_sel.cin;
  assign o_wr_en      = r_sel.wr_en;
`ifdef ALU_DBL_EN
  assign o_half       = r_half;
`else
  assign o_half       = 1'b0;
`endif
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = r_err;
  assign o_z          = r_z;
  assign o_c          = r_c;
  assign o_n          = r_n;
  assign o_v          = r_v;

endmodule
